// File: rtl/mips_alu.sv
// Registered MIPS ALU: AND/OR/ADD/SUB/SLT selected by alucontrol, with a zero flag.
// The result and the zero flag are captured in output registers, giving one cycle of latency.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic signed [WIDTH-1:0] bb;
  logic signed [WIDTH-1:0] sum;
  logic        [WIDTH-1:0] result_d;
  logic        [WIDTH-1:0] result_q;
  logic                    zero_d;
  logic                    zero_q;

  // Signed less-than taken from the subtractor.
  // The overflow term corrects the sign bit when A-B wraps.
  function automatic logic slt_bit(input logic a_msb, input logic b_msb, input logic s_msb);
    logic ovf;
    ovf = (a_msb != b_msb) && (s_msb != a_msb);
    return s_msb ^ ovf;
  endfunction

  always_comb begin
    bb  = alucontrol[2] ? ~srcb : srcb;
    sum = srca + bb + {{(WIDTH-1){1'b0}}, alucontrol[2]};
    result_d = '0;
    case (alucontrol[1:0])
      2'b00: result_d = srca & bb;
      2'b01: result_d = srca | bb;
      2'b10: result_d = sum;
      default: result_d[0] = alucontrol[2] ? slt_bit(srca[WIDTH-1], srcb[WIDTH-1], sum[WIDTH-1])
                                           : sum[WIDTH-1];
    endcase
    zero_d = (result_d == '0);
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_mips_alu.sv
// Bench for mips_alu: directed vector table, reset/latency sequences and a random sweep
// compared against a reference model built on plain arithmetic.
module tb_mips_alu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  srca;
  logic [W-1:0]  srcb;
  logic [2:0]    alucontrol;
  logic [W-1:0]  result;
  logic          zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   ctl;
    logic [W-1:0] er;
    logic         ez;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  mips_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .srca(srca),
    .srcb(srcb),
    .alucontrol(alucontrol),
    .result(result),
    .zero(zero)
  );

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] c);
    logic [W-1:0] s;
    s = a + b;
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return s;
      3'd3: return {{(W-1){1'b0}}, s[W-1]};
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    @(negedge clk);
    srca = a;
    srcb = b;
    alucontrol = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] ra, rb, er;
    logic [2:0]   rc;

    vecs[0]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0};
    vecs[1]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b0};
    vecs[2]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h00F000F0, 1'b0};
    vecs[3]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 32'hF0FFF0FF, 1'b0};
    vecs[4]  = '{32'd5,        32'd3,        3'b110, 32'd2,        1'b0};
    vecs[5]  = '{32'd7,        32'd7,        3'b110, 32'd0,        1'b1};
    vecs[6]  = '{32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1};
    vecs[7]  = '{32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0};
    vecs[8]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 32'd0,        1'b1};
    vecs[9]  = '{32'h80000000, 32'd1,        3'b111, 32'd1,        1'b0};
    vecs[10] = '{32'h80000000, 32'd0,        3'b011, 32'd1,        1'b0};
    vecs[11] = '{32'd1,        32'd1,        3'b011, 32'd0,        1'b1};

    reset = 1'b1;
    srca = '0;
    srcb = '0;
    alucontrol = 3'b000;
    #2;
    check("reset_result", result, '0);
    check("reset_zero", {31'b0, zero}, 32'd1);

    @(negedge clk);
    reset = 1'b0;
    apply(32'd5, 32'd3, 3'b010);
    check("pre_reset_add", result, 32'd8);
    check("pre_reset_zero", {31'b0, zero}, 32'd0);

    // Async assertion mid-cycle, then held across an edge with new inputs pending.
    @(negedge clk);
    srca = 32'd9;
    srcb = 32'd4;
    alucontrol = 3'b010;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_result", result, '0);
    check("async_reset_zero", {31'b0, zero}, 32'd1);
    @(posedge clk);
    #1;
    check("held_reset_result", result, '0);
    check("held_reset_zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    apply(32'd5, 32'd3, 3'b010);
    check("post_reset_add", result, 32'd8);
    check("post_reset_zero", {31'b0, zero}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].ctl);
      check($sformatf("vec%0d_result", i), result, vecs[i].er);
      check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].ez});
    end

    for (int i = 0; i < 256; i++) begin
      ra = pick_operand();
      rb = (i % 16 == 5) ? ra : pick_operand();
      rc = i[2:0];
      er = ref_alu(ra, rb, rc);
      apply(ra, rb, rc);
      check($sformatf("sweep%0d_ctl%0d_a%h_b%h", i, rc, ra, rb), result, er);
      check($sformatf("sweep%0d_zero", i), {31'b0, zero}, {31'b0, (er == '0)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
